// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path: frame sizing, read FSM states and bit reversal.
// Complex words are packed as {re, im}, with re in the upper half.
package fft_pkg;

    localparam int DEF_N_LOG2 = 4;
    localparam int DEF_N      = 2 ** DEF_N_LOG2;
    localparam int BITREV_MAX = 10;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    // Reverse the low nbits of value; bits at and above nbits come back zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] value,
                                                      input int nbits);
        logic [BITREV_MAX-1:0] rev;
        rev = {<<{value}};
        return rev >> (BITREV_MAX - nbits);
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame buffer: synchronous write, registered write-first read.
// The top-level bank select is the address MSB.
module fft_reorder_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value when re is low, so the output data stays put while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the SDF FFT output, ping-pong banked.
//   state | meaning
//   IDLE  | no full bank pending; outputs invalid, data held
//   READ  | streaming bank rd_bank in natural order, one bin per cycle
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_LOG2 = DEF_N_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_in,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    enable_out,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    frame_start
);

    logic [N_LOG2-1:0]  wr_cnt;
    logic [N_LOG2-1:0]  rd_cnt;
    logic [N_LOG2-1:0]  rd_cnt_nxt;
    logic               wr_bank;
    logic               rd_bank;
    logic               rd_bank_nxt;
    logic               rd_other;
    logic [1:0]         bank_full;
    logic [1:0]         full_set;
    logic [1:0]         full_clr;
    logic               wr_done;
    logic               rd_en;
    rd_state_t          state;
    rd_state_t          state_nxt;
    logic [N_LOG2:0]    waddr;
    logic [N_LOG2:0]    raddr;
    logic [2*WIDTH-1:0] rd_data;

    assign wr_done  = enable_in && (&wr_cnt);
    assign rd_other = ~rd_bank;
    assign full_set = {wr_done & wr_bank, wr_done & ~wr_bank};
    assign waddr    = {wr_bank, N_LOG2'(bitrev(BITREV_MAX'(wr_cnt), N_LOG2))};
    assign raddr    = {rd_bank, rd_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (enable_in) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (&wr_cnt) wr_bank <= ~wr_bank;
        end
    end

    // Set wins over clear: an overrun simply overwrites the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bank_full <= '0;
        else
            bank_full <= (bank_full & ~full_clr) | full_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    // A frame completing on this edge counts as full already, so bin 0 leaves one edge later.
    always_comb begin
        state_nxt   = state;
        rd_cnt_nxt  = rd_cnt;
        rd_bank_nxt = rd_bank;
        full_clr    = '0;
        rd_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rd_bank] || (wr_done && (wr_bank == rd_bank))) begin
                    state_nxt  = READ;
                    rd_cnt_nxt = '0;
                end
            end
            READ: begin
                rd_en      = 1'b1;
                rd_cnt_nxt = rd_cnt + 1'b1;
                if (&rd_cnt) begin
                    full_clr[rd_bank] = 1'b1;
                    rd_bank_nxt       = rd_other;
                    if (!(bank_full[rd_other] || (wr_done && (wr_bank == rd_other))))
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_out  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            enable_out  <= rd_en;
            frame_start <= rd_en && (rd_cnt == '0);
        end
    end

    fft_reorder_ram #(
        .DATA_W(2 * WIDTH),
        .ADDR_W(N_LOG2 + 1)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (enable_in),
        .waddr(waddr),
        .wdata({in_re, in_im}),
        .re   (rd_en),
        .raddr(raddr),
        .rdata(rd_data)
    );

    assign out_re = rd_data[2*WIDTH-1:WIDTH];
    assign out_im = rd_data[WIDTH-1:0];

    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        !(wr_done && bank_full[wr_bank]));

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side companion to the radix-2^2 SDF pipeline stages.
- Accepts one N-point frame per burst in bit-reversed order, as it leaves the last SDF stage, and emits the same frame in natural order (bin 0..N-1).
- Uses ping-pong buffering so back-to-back frames stream without stalls.
- Sits after the final sdf stage and before downstream consumers (magnitude, host readout).

Parameters:
- WIDTH, 8, bit width of each real/imag sample (two's complement).
- N_LOG2, 4, log2 of frame length; N = 2**N_LOG2; legal range 2..10.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable_in  input  1  input sample valid; same meaning as sdf stage enable_out.
- in_re  input  WIDTH  real part, signed, bit-reversed order.
- in_im  input  WIDTH  imag part, signed, bit-reversed order.
- enable_out  output  1  output sample valid, registered.
- out_re  output  WIDTH  real part, signed, natural order, registered.
- out_im  output  WIDTH  imag part, signed, natural order, registered.
- frame_start  output  1  high with the bin-0 output sample only, registered.

Behaviour:
- Reset (async, rst=1): enable_out=0, frame_start=0, out_re=0, out_im=0, wr_cnt=0, wr_bank=0, rd_cnt=0, rd_active=0, both bank_full flags=0. RAM contents are not reset.
- Storage: two banks of N complex words, each 2*WIDTH bits.
- Write side:
  - Each cycle with enable_in=1 writes {in_re,in_im} to bank wr_bank at address bitrev(wr_cnt), then wr_cnt increments mod N.
  - Gaps in enable_in pause the write side only; wr_cnt holds.
  - On the cycle wr_cnt==N-1 && enable_in: set bank_full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side FSM, states IDLE and READ:
  - IDLE -> READ when bank_full[rd_bank]=1. rd_cnt=0, and rd_bank is the oldest full bank.
  - In READ, each cycle:
    - out_re/out_im <= mem[rd_bank][rd_cnt], enable_out <= 1.
    - frame_start <= (rd_cnt==0).
    - rd_cnt increments.
  - At rd_cnt==N-1: clear bank_full[rd_bank] and toggle rd_bank.
    - If the other bank is already full, stay in READ with rd_cnt=0 (gapless output).
    - Otherwise go to IDLE.
  - In IDLE, enable_out <= 0 and frame_start <= 0. out_re/out_im hold their last value.
- Latency: if edge k captures the last input sample of a frame, bin 0 is registered at edge k+1. Output is then N contiguous valid cycles.
- Read-during-write: a bank is never read and written in the same cycle. The write-first RAM requirement applies only to the same-cycle handoff at k+1, where data written at edge k is visible on the read at edge k+1.
- Overrun: cannot occur. A frame takes ≥N input cycles and a read takes exactly N cycles.
  - Defensive rule: if enable_in completes a frame into a bank whose bank_full is still set, overwrite it and raise no flag. This case is unreachable in a legal pipeline and is asserted against in simulation.
- Reset mid-frame: the partial input frame and any in-progress output are discarded. After rst deasserts, the next enable_in sample is treated as bitrev index 0.
- Arithmetic: none. Data passes bit-exact; no scaling or rounding.

Decomposition:
- Shared package fft_pkg:
  - function bitrev(value, nbits).
  - localparam N derived from N_LOG2.
  - Complex word packing convention {re, im}.
- Sub-module fft_reorder_ram:
  - Simple dual-port RAM, depth 2*N, width 2*WIDTH.
  - Synchronous write, registered read, write-first.
  - Bank select is the MSB of the address.
- Top level holds the counters, bank_full flags, FSM and output registers.

Test Plan:
- N_LOG2=4, rst pulse then one frame. Input sample n carries re=bitrev4(n), im=-bitrev4(n) (input 1 is 8, -8). Required: 16 contiguous outputs re=0..15, im=0..-15; frame_start only on the first; enable_out rises at edge k+1.
- Three back-to-back frames, continuous enable_in, frame f adds 16*f to re. Required: 48 contiguous enable_out cycles, frame_start at outputs 0, 16 and 32, no gaps.
- Same frame, but enable_in toggles 1/0 each cycle (32 input cycles). Required: output identical to the first test and still 16 contiguous cycles.
- Assert rst after 7 samples of a frame, deassert, then send a full frame. Required: no output for the partial frame; full frame emitted correctly; enable_out=0 throughout reset.
- N_LOG2=3, WIDTH=12, values ±2047. Required: natural order restored (bitrev3 sequence 0,4,2,6,1,5,3,7 maps to 0..7) with values bit-exact at the extremes.
- Idle: no enable_in for 100 cycles after reset. Required: enable_out=0, frame_start=0, out_re=out_im=0 throughout.
